// File: rtl/microondas_pkg.sv
// Shared codes and limits for the microwave cook-time controller.
package microondas_pkg;

  localparam int STATE_W       = 3;
  localparam int BCD_W         = 4;
  localparam int BCD_MAX       = 9;
  localparam int SEC_TENS_MAX  = 5;
  localparam int QUICK_ADD_SEC = 30;
  localparam int SEC_PER_MIN   = 60;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_ENTRY   = 3'd1;
  localparam logic [STATE_W-1:0] ST_COOKING = 3'd2;
  localparam logic [STATE_W-1:0] ST_PAUSED  = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE    = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = ST_IDLE,
    ENTRY   = ST_ENTRY,
    COOKING = ST_COOKING,
    PAUSED  = ST_PAUSED,
    DONE    = ST_DONE
  } state_e;

endpackage

// File: rtl/cook_tick_gen.sv
// One-second tick prescaler: counts 0..TICKS_PER_SEC-1 while enabled, one-cycle tick on wrap.
module cook_tick_gen #(
  parameter int TICKS_PER_SEC = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/cook_timer_ctrl.sv
// Microwave cook-time controller: BCD MM:SS keypad entry, one-second countdown, magnetron and beeper.
// Optional build macro QUICK_START_EN enables the +30 s quick-start key behaviour.
module cook_timer_ctrl
  import microondas_pkg::*;
#(
  parameter int TICKS_PER_SEC = 8,
  parameter int BEEP_CYCLES   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_valid,
  input  logic [BCD_W-1:0]   key_digit,
  input  logic               start,
  input  logic               stop,
  input  logic               door_open,
  output logic [BCD_W-1:0]   min_tens,
  output logic [BCD_W-1:0]   min_ones,
  output logic [BCD_W-1:0]   sec_tens,
  output logic [BCD_W-1:0]   sec_ones,
  output logic               magnetron_on,
  output logic               done_beep,
  output logic [STATE_W-1:0] state
);

  localparam int BW = $clog2(BEEP_CYCLES + 1);
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYCLES - 1);

  state_e        state_q, state_d;
  logic [15:0]   time_q, time_d;
  logic [BW-1:0] beep_q, beep_d;
  logic          pre_en, pre_clr, tick;
  logic          key_ok;
  logic [15:0]   cook_t;

  // Borrowing BCD decrement; never called with 00:00.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = t;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else if (st != 4'd0) begin
      st = st - 4'd1;
      so = 4'(BCD_MAX);
    end else if (mo != 4'd0) begin
      mo = mo - 4'd1;
      st = 4'(SEC_TENS_MAX);
      so = 4'(BCD_MAX);
    end else begin
      mt = mt - 4'd1;
      mo = 4'(BCD_MAX);
      st = 4'(SEC_TENS_MAX);
      so = 4'(BCD_MAX);
    end
    return {mt, mo, st, so};
  endfunction

`ifdef QUICK_START_EN
  // Adds QUICK_ADD_SEC seconds, carrying into minutes and saturating at 99:59.
  function automatic logic [15:0] bcd_add_quick(input logic [15:0] t);
    logic [7:0] mins, secs;
    mins = 8'(t[15:12]) * 8'd10 + 8'(t[11:8]);
    secs = 8'(t[7:4]) * 8'd10 + 8'(t[3:0]);
    if (secs >= 8'(SEC_PER_MIN - QUICK_ADD_SEC)) begin
      secs = secs + 8'(QUICK_ADD_SEC) - 8'(SEC_PER_MIN);
      mins = mins + 8'd1;
    end else begin
      secs = secs + 8'(QUICK_ADD_SEC);
    end
    if (mins > 8'd99) begin
      return 16'h9959;
    end
    return {4'(mins / 8'd10), 4'(mins % 8'd10), 4'(secs / 8'd10), 4'(secs % 8'd10)};
  endfunction

  localparam logic [15:0] QUICK_LOAD = {8'h00, 4'(QUICK_ADD_SEC / 10), 4'(QUICK_ADD_SEC % 10)};
`endif

  cook_tick_gen #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (tick)
  );

  assign key_ok = key_valid && (key_digit <= 4'(BCD_MAX)) && !start && !stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      time_q  <= '0;
      beep_q  <= '0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      beep_q  <= beep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    beep_d  = '0;
    pre_en  = 1'b0;
    pre_clr = 1'b0;
    cook_t  = time_q;
    case (state_q)
      IDLE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start) begin
`ifdef QUICK_START_EN
          if (!door_open) begin
            state_d = COOKING;
            time_d  = QUICK_LOAD;
            pre_clr = 1'b1;
          end
`endif
        end else if (key_ok) begin
          time_d  = {time_q[11:0], key_digit};
          state_d = ENTRY;
        end
      end
      ENTRY: begin
        if (stop) begin
          state_d = IDLE;
          time_d  = '0;
        end else if (start) begin
          if (time_q == 16'h0000) begin
            state_d = IDLE;
          end else if (!door_open) begin
            state_d = COOKING;
            pre_clr = 1'b1;
          end
        end else if (key_ok) begin
          time_d = {time_q[11:0], key_digit};
        end
      end
      COOKING: begin
        // Pausing freezes the prescaler so the partial second resumes later.
        if (door_open || stop) begin
          state_d = PAUSED;
        end else begin
          pre_en = 1'b1;
          if (tick && time_q != 16'h0000) begin
            cook_t = bcd_dec(time_q);
          end
`ifdef QUICK_START_EN
          if (start) begin
            cook_t = bcd_add_quick(cook_t);
          end
`endif
          time_d = cook_t;
          if (tick && cook_t == 16'h0000) begin
            state_d = DONE;
          end
        end
      end
      PAUSED: begin
        if (stop) begin
          state_d = IDLE;
          time_d  = '0;
        end else if (start && !door_open) begin
          state_d = COOKING;
        end
      end
      DONE: begin
        if (stop || beep_q == BEEP_LAST) begin
          state_d = IDLE;
          time_d  = '0;
        end else begin
          beep_d = beep_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        time_d  = '0;
      end
    endcase
  end

  assign {min_tens, min_ones, sec_tens, sec_ones} = time_q;
  assign magnetron_on = (state_q == COOKING);
  assign done_beep    = (state_q == DONE);
  assign state        = state_q;

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Directed bench for cook_timer_ctrl with a seconds-level behavioural model checked every cycle.
module tb_cook_timer_ctrl;

  localparam int TPS  = 8;
  localparam int BEEP = 16;
`ifdef QUICK_START_EN
  localparam bit QS = 1'b1;
`else
  localparam bit QS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       start, stop, door_open;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       magnetron_on, done_beep;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  cook_timer_ctrl #(.TICKS_PER_SEC(TPS), .BEEP_CYCLES(BEEP)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop(stop), .door_open(door_open),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .magnetron_on(magnetron_on), .done_beep(done_beep), .state(state)
  );

  always #5 clk = ~clk;

  // Model: minutes and seconds as plain integers, elapsed cycles in the current second.
  typedef struct {
    int st;
    int mins;
    int secs;
    int pre;
    int beep;
  } model_t;

  model_t m;

  function automatic model_t model_next(model_t c, logic kv, logic [3:0] kd,
                                        logic sta, logic sto, logic door);
    model_t n = c;
    bit kok = kv && (kd <= 4'd9) && !sta && !sto;
    bit tk = 1'b0;
    case (c.st)
      0: begin
        if (sto) begin
        end else if (sta) begin
          if (QS && !door) begin n.st = 2; n.mins = 0; n.secs = 30; n.pre = 0; end
        end else if (kok) begin
          n.mins = (c.mins % 10) * 10 + c.secs / 10;
          n.secs = (c.secs % 10) * 10 + int'(kd);
          n.st = 1;
        end
      end
      1: begin
        if (sto) begin n.st = 0; n.mins = 0; n.secs = 0; end
        else if (sta) begin
          if (c.mins == 0 && c.secs == 0) n.st = 0;
          else if (!door) begin n.st = 2; n.pre = 0; end
        end else if (kok) begin
          n.mins = (c.mins % 10) * 10 + c.secs / 10;
          n.secs = (c.secs % 10) * 10 + int'(kd);
        end
      end
      2: begin
        if (door || sto) n.st = 3;
        else begin
          n.pre = c.pre + 1;
          if (n.pre == TPS) begin n.pre = 0; tk = 1'b1; end
          if (tk) begin
            if (n.secs > 0) n.secs = n.secs - 1;
            else begin n.mins = n.mins - 1; n.secs = 59; end
          end
          if (QS && sta) begin
            if (n.secs + 30 >= 60) begin n.secs = n.secs - 30; n.mins = n.mins + 1; end
            else n.secs = n.secs + 30;
            if (n.mins > 99) begin n.mins = 99; n.secs = 59; end
          end
          if (tk && n.mins == 0 && n.secs == 0) begin n.st = 4; n.beep = 0; end
        end
      end
      3: begin
        if (sto) begin n.st = 0; n.mins = 0; n.secs = 0; end
        else if (sta && !door) n.st = 2;
      end
      default: begin
        if (sto || c.beep + 1 >= BEEP) begin n.st = 0; n.mins = 0; n.secs = 0; n.beep = 0; end
        else n.beep = c.beep + 1;
      end
    endcase
    return n;
  endfunction

  function automatic logic [15:0] model_disp(model_t c);
    return {4'(c.mins / 10), 4'(c.mins % 10), 4'(c.secs / 10), 4'(c.secs % 10)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{st: 0, mins: 0, secs: 0, pre: 0, beep: 0};
    else        m <= model_next(m, key_valid, key_digit, start, stop, door_open);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [15:0] disp;
  assign disp = {min_tens, min_ones, sec_tens, sec_ones};

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_state", 32'(state), 32'(m.st));
      chk("model_disp", 32'(disp), 32'(model_disp(m)));
      chk("model_mag", 32'(magnetron_on), 32'(m.st == 2));
      chk("model_beep", 32'(done_beep), 32'(m.st == 4));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1; key_digit = d;
    step(1);
    key_valid = 1'b0; key_digit = 4'd0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(1); stop = 1'b0;
  endtask

  int mag_cnt, beep_cnt, guard;
  bit seen_done;

  initial begin
    rst_n = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
    start = 1'b0; stop = 1'b0; door_open = 1'b0;
    step(3);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_disp", 32'(disp), 32'h0000);
    chk("reset_mag", 32'(magnetron_on), 32'd0);
    chk("reset_beep", 32'(done_beep), 32'd0);
    rst_n = 1'b1;
    step(2);

    // Entry shift and countdown with minute borrow.
    press(4'd1); press(4'd0); press(4'd5);
    chk("entry_state", 32'(state), 32'd1);
    chk("entry_disp", 32'(disp), 32'h0105);
    pulse_start();
    chk("cook_state", 32'(state), 32'd2);
    step(7);
    chk("before_tick", 32'(disp), 32'h0105);
    step(1);
    chk("first_tick", 32'(disp), 32'h0104);
    step(40);
    chk("borrow", 32'(disp), 32'h0059);
    pulse_stop();
    chk("stop_pause", 32'(state), 32'd3);
    chk("pause_hold", 32'(disp), 32'h0059);
    pulse_stop();
    chk("stop_clear_state", 32'(state), 32'd0);
    chk("stop_clear_disp", 32'(disp), 32'h0000);

    // stop and start together while cooking: stop wins.
    press(4'd4); pulse_start();
    start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
    chk("prio_stop_start", 32'(state), 32'd3);
    pulse_stop();

    // Completion and beeper.
    press(4'd2); pulse_start();
    mag_cnt = 0; beep_cnt = 0; guard = 0; seen_done = 1'b0;
    while (state != 3'd0 && guard < 200) begin
      if (magnetron_on) mag_cnt++;
      if (done_beep) beep_cnt++;
      if (state == 3'd4 && !seen_done) begin
        seen_done = 1'b1;
        chk("done_disp", 32'(disp), 32'h0000);
      end
      step(1);
      guard++;
    end
    chk("done_timeout", 32'(guard < 200), 32'd1);
    chk("mag_cycles", 32'(mag_cnt), 32'd16);
    chk("beep_cycles", 32'(beep_cnt), 32'd16);
    chk("done_to_idle", 32'(state), 32'd0);

    // Door interlock at prescaler 3, resume keeps the partial second.
    press(4'd0); press(4'd9); pulse_start();
    step(3);
    door_open = 1'b1; step(1);
    chk("door_pause", 32'(state), 32'd3);
    step(3);
    chk("door_frozen", 32'(disp), 32'h0009);
    door_open = 1'b0; step(1);
    pulse_start();
    chk("resume_state", 32'(state), 32'd2);
    step(4);
    chk("resume_no_tick", 32'(disp), 32'h0009);
    step(1);
    chk("resume_tick", 32'(disp), 32'h0008);
    pulse_stop(); pulse_stop();

    // Door blocks start in ENTRY; digit 0xA is ignored.
    press(4'd3);
    door_open = 1'b1; pulse_start(); door_open = 1'b0;
    chk("door_block_start", 32'(state), 32'd1);
    press(4'hA);
    chk("bad_digit", 32'(disp), 32'h0003);
    pulse_stop();
    chk("entry_stop", 32'(state), 32'd0);

`ifdef QUICK_START_EN
    pulse_start();
    chk("quick_state", 32'(state), 32'd2);
    chk("quick_load", 32'(disp), 32'h0030);
    step(1);
    pulse_start();
    chk("quick_add", 32'(disp), 32'h0100);
    pulse_stop(); pulse_stop();
`else
    pulse_start();
    chk("idle_start_ignored", 32'(state), 32'd0);
`endif

    // Reset mid-cook aborts immediately.
    press(4'd1); press(4'd0); pulse_start();
    step(5);
    rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_disp", 32'(disp), 32'h0000);
    chk("rst_mag", 32'(magnetron_on), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cook_timer_ctrl.md
Name: cook_timer_ctrl

Overview:
- Microwave cook-time controller.
- Sits directly downstream of the 3-bit clock-division counter stage; uses a 0..TICKS_PER_SEC-1 prescale to derive a one-second tick.
- Accepts keypad digits as MM:SS in BCD and counts down while cooking.
- Drives the magnetron enable, the end-of-cook beeper, and four BCD digits for the display stage.

Parameters:
- TICKS_PER_SEC, 8, clk cycles per one-second tick; must be >= 2; prescaler width = $clog2(TICKS_PER_SEC).
- BEEP_CYCLES, 16, clk cycles done_beep is held high in DONE; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_valid  input  1  single-cycle strobe qualifying key_digit.
- key_digit  input  4  BCD digit; values >9 ignored.
- start  input  1  start/resume request, level sampled each cycle.
- stop  input  1  pause/clear request, level sampled each cycle.
- door_open  input  1  door interlock, 1 = open.
- min_tens  output  4  BCD minutes tens.
- min_ones  output  4  BCD minutes ones.
- sec_tens  output  4  BCD seconds tens.
- sec_ones  output  4  BCD seconds ones.
- magnetron_on  output  1  high exactly while state == COOKING.
- done_beep  output  1  high while state == DONE.
- state  output  3  current state code.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE.
  - All digits = 0, prescaler = 0, beep counter = 0.
  - magnetron_on = 0, done_beep = 0.
  - Reset mid-cook aborts immediately.
- States: IDLE = 0, ENTRY = 1, COOKING = 2, PAUSED = 3, DONE = 4. Codes 5..7 are illegal and go to IDLE with digits cleared.
- Priority per cycle: door_open > stop > start > key_valid.
- Key entry, allowed only in IDLE and ENTRY:
  - A valid digit shifts left: min_tens <= min_ones, min_ones <= sec_tens, sec_tens <= sec_ones, sec_ones <= key_digit.
  - State becomes ENTRY.
  - Keys are ignored in COOKING, PAUSED and DONE.
- start:
  - From ENTRY with door closed and time != 00:00: go to COOKING and clear the prescaler.
  - From ENTRY with time == 00:00: go to IDLE.
  - From PAUSED with door closed: go to COOKING; the prescaler is kept, so the partial second resumes.
  - From IDLE: ignored, unless QUICK_START_EN is defined.
- stop:
  - COOKING -> PAUSED, digits held.
  - PAUSED, ENTRY or DONE -> IDLE, digits cleared.
  - IDLE: no effect.
- door_open in COOKING: go to PAUSED next edge. In any other state door_open only blocks start.
- Prescaler (COOKING only):
  - Increments each cycle; at TICKS_PER_SEC-1 it wraps to 0 and asserts the internal tick.
  - The first decrement occurs TICKS_PER_SEC cycles after entering COOKING from ENTRY.
- Decrement on tick:
  - If sec_ones > 0: sec_ones - 1.
  - Else if sec_tens > 0: sec_tens - 1, sec_ones = 9.
  - Else if min_ones > 0: min_ones - 1, sec_tens = 5, sec_ones = 9.
  - Else: min_tens - 1, min_ones = 9, sec_tens = 5, sec_ones = 9.
  - Entered sec_tens > 5 is legal; it simply counts down.
- Completion: a tick that leaves 00:00 moves the block to DONE on the same edge. magnetron_on drops the cycle after the last decrement.
- DONE: done_beep = 1 for BEEP_CYCLES cycles, then automatic return to IDLE. Digits stay 00:00.
- No wrap below 00:00; the decrementer is never applied to 00:00.

Optional Feature:
- Macro QUICK_START_EN.
- Defined: start in IDLE with door closed loads 00:30 and enters COOKING with the prescaler cleared. Each additional start during COOKING adds 30 s in BCD, saturating at 99:59.
- Undefined: start in IDLE and start in COOKING are ignored.

Decomposition:
- Shared package microondas_pkg holds:
  - State code localparams (IDLE..DONE) and the state width (3).
  - BCD digit width (4), BCD_MAX = 9, SEC_TENS_MAX = 5.
  - QUICK_ADD_SEC = 30.
- One sub-module is natural: cook_tick_gen.
  - Parameterised prescaler with enable and synchronous clear.
  - Emits a one-cycle tick.
- The BCD decrementer stays inline as a combinational function.

Test Plan:
- Reset mid-cook: keys 1,0 then start; after 5 clocks pull rst_n low -> immediately state = 0, digits 00:00, magnetron_on = 0.
- Entry shift and countdown: keys 1,0,5 then start, TICKS_PER_SEC = 8 -> display 01:05; after 8 clocks 01:04; after 40 more clocks 00:59, with borrow across minutes.
- Completion: keys 2 then start -> magnetron_on = 1 for 16 cycles; the edge that leaves 00:00 enters DONE; done_beep = 1 for 16 cycles, then state = IDLE.
- Door interlock: cooking 00:09, door_open = 1 at prescaler 3 -> PAUSED, digits frozen. Door closes, then start -> COOKING; next decrement 5 cycles later.
- Priority: in COOKING assert stop and start together -> PAUSED. In ENTRY with door open, start -> stays ENTRY. A key with digit 0xA -> ignored.
- Quick start (QUICK_START_EN defined): start in IDLE -> 00:30 and COOKING; a second start 2 cycles later -> 01:00.
